// File: rtl/efuse_usr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : efuse_usr_ctrl
// Purpose  : Qualifies the 32-bit user eFuse word after reset. It waits a
//            settle interval, double-samples the word, retries on disagreement
//            and optionally checks parity. It then serves byte reads to the
//            register side over a req/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module efuse_usr_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,  // 1..65535
  parameter int unsigned MAX_RETRY     = 3,   // 0..15
  parameter int unsigned PARITY_EN     = 0    // 1: bit 31 is even parity of [30:0]
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] efuse_usr,
  input  logic        rescan,
  input  logic        rd_req,
  input  logic [1:0]  rd_addr,
  output logic        rd_ack,
  output logic [7:0]  rd_data,
  output logic        rd_err,
  output logic [31:0] value,
  output logic        valid,
  output logic        error,
  output logic        parity_err,
  output logic        busy,
  output logic [3:0]  retry_cnt
);

  localparam logic [15:0] c_settle_last = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  c_max_retry   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_CAP_A  = 3'd1,
    ST_CAP_B  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] sample_a_q, sample_a_d;
  logic [31:0] sample_b_q, sample_b_d;
  logic [31:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        parity_err_q, parity_err_d;
  logic [3:0]  retry_q, retry_d;
  logic        busy_q, busy_d;
  logic        pend_q, pend_d;
  logic [1:0]  pend_addr_q, pend_addr_d;
  logic        rd_ack_q, rd_ack_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_err_q, rd_err_d;

  // High on the edge where the scan reaches DONE or FAIL; pending reads are
  // answered on that same edge so the ack lines up with valid/error.
  logic        enter_term;
  logic        in_term;
  logic        accept;
  logic        serve_now;
  logic        serve;
  logic [1:0]  sel_addr;

  assign in_term = (state_q == ST_DONE) || (state_q == ST_FAIL);

  // Scan sequencer: settle, double-sample, compare, then hold the verdict.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sample_a_d   = sample_a_q;
    sample_b_d   = sample_b_q;
    value_d      = value_q;
    valid_d      = valid_q;
    error_d      = error_q;
    parity_err_d = parity_err_q;
    retry_d      = retry_q;
    enter_term   = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == c_settle_last) begin
          cnt_d   = '0;
          state_d = ST_CAP_A;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CAP_A: begin
        sample_a_d = efuse_usr;
        state_d    = ST_CAP_B;
      end
      ST_CAP_B: begin
        sample_b_d = efuse_usr;
        state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        if (sample_a_q != sample_b_q) begin
          if (retry_q < c_max_retry) begin
            retry_d = retry_q + 4'd1;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            error_d    = 1'b1;
            state_d    = ST_FAIL;
            enter_term = 1'b1;
          end
        end else if ((PARITY_EN != 0) && (^sample_a_q)) begin
          // A stable word with bad parity will not improve on a re-scan.
          error_d      = 1'b1;
          parity_err_d = 1'b1;
          state_d      = ST_FAIL;
          enter_term   = 1'b1;
        end else begin
          value_d    = sample_a_q;
          valid_d    = 1'b1;
          state_d    = ST_DONE;
          enter_term = 1'b1;
        end
      end
      ST_DONE, ST_FAIL: begin
        if (rescan) begin
          // value is deliberately kept until the next successful scan.
          state_d      = ST_SETTLE;
          cnt_d        = '0;
          valid_d      = 1'b0;
          error_d      = 1'b0;
          parity_err_d = 1'b0;
          retry_d      = '0;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = !((state_d == ST_DONE) || (state_d == ST_FAIL));
  end

  // Read port: accept one request at a time, answer immediately when settled,
  // otherwise park it until the scan reaches a verdict.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    accept      = rd_req && !pend_q && !rd_ack_q;
    // A same-cycle rescan takes priority, so the read waits for fresh data.
    serve_now   = accept && in_term && !rescan;
    if (accept && !serve_now) begin
      pend_d      = 1'b1;
      pend_addr_d = rd_addr;
    end
    serve    = serve_now || (pend_d && enter_term);
    sel_addr = serve_now ? rd_addr : pend_addr_d;
    if (serve && !serve_now) begin
      pend_d = 1'b0;
    end
    rd_ack_d  = serve;
    rd_err_d  = serve && error_d;
    rd_data_d = (serve && !error_d) ? 8'(value_d >> {sel_addr, 3'b000}) : 8'h00;
  end

  // State and output registers; reset is asynchronous so outputs drop at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SETTLE;
      cnt_q        <= '0;
      sample_a_q   <= '0;
      sample_b_q   <= '0;
      value_q      <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
      parity_err_q <= 1'b0;
      retry_q      <= '0;
      busy_q       <= 1'b1;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      rd_ack_q     <= 1'b0;
      rd_data_q    <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sample_a_q   <= sample_a_d;
      sample_b_q   <= sample_b_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
      parity_err_q <= parity_err_d;
      retry_q      <= retry_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      rd_ack_q     <= rd_ack_d;
      rd_data_q    <= rd_data_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign value      = value_q;
  assign valid      = valid_q;
  assign error      = error_q;
  assign parity_err = parity_err_q;
  assign busy       = busy_q;
  assign retry_cnt  = retry_q;
  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;
  assign rd_err     = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_efuse_usr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_efuse_usr_ctrl
// Purpose  : Directed bench for efuse_usr_ctrl. Two instances with different
//            parameters run side by side; a timeline model predicts every
//            output each cycle and literal checks pin key moments.
// Revision : 1.0 - initial release
// ============================================================================
module tb_efuse_usr_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Per-instance parameters: settle length, retry budget, parity enable.
  int p_s   [2] = '{4, 5};
  int p_mr  [2] = '{3, 2};
  int p_par [2] = '{0, 1};

  logic [31:0] efuse      [2];
  logic        rescan     [2];
  logic        rd_req     [2];
  logic [1:0]  rd_addr    [2];
  logic        rd_ack     [2];
  logic [7:0]  rd_data    [2];
  logic        rd_err     [2];
  logic [31:0] value      [2];
  logic        valid      [2];
  logic        error      [2];
  logic        parity_err [2];
  logic        busy       [2];
  logic [3:0]  retry_cnt  [2];

  efuse_usr_ctrl #(.SETTLE_CYCLES(4), .MAX_RETRY(3), .PARITY_EN(0)) u0 (
    .clock(clk), .reset_n(rst_n), .efuse_usr(efuse[0]), .rescan(rescan[0]),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_ack(rd_ack[0]),
    .rd_data(rd_data[0]), .rd_err(rd_err[0]), .value(value[0]),
    .valid(valid[0]), .error(error[0]), .parity_err(parity_err[0]),
    .busy(busy[0]), .retry_cnt(retry_cnt[0])
  );

  efuse_usr_ctrl #(.SETTLE_CYCLES(5), .MAX_RETRY(2), .PARITY_EN(1)) u1 (
    .clock(clk), .reset_n(rst_n), .efuse_usr(efuse[1]), .rescan(rescan[1]),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_ack(rd_ack[1]),
    .rd_data(rd_data[1]), .rd_err(rd_err[1]), .value(value[1]),
    .valid(valid[1]), .error(error[1]), .parity_err(parity_err[1]),
    .busy(busy[1]), .retry_cnt(retry_cnt[1])
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos counts edges since the current attempt began; an attempt samples at
  // edges S+1 and S+2 and decides at edge S+3.
  int          m_pos   [2] = '{0, 0};
  logic        m_term  [2] = '{0, 0};
  logic [31:0] m_a     [2] = '{0, 0};
  logic [31:0] m_b     [2] = '{0, 0};
  logic [31:0] m_value [2] = '{0, 0};
  logic        m_valid [2] = '{0, 0};
  logic        m_err   [2] = '{0, 0};
  logic        m_perr  [2] = '{0, 0};
  int          m_retry [2] = '{0, 0};
  logic        m_pend  [2] = '{0, 0};
  logic [1:0]  m_paddr [2] = '{0, 0};
  logic        m_ack   [2] = '{0, 0};
  logic [7:0]  m_rdata [2] = '{0, 0};
  logic        m_rerr  [2] = '{0, 0};

  task automatic model_reset(input int i);
    m_pos[i] = 0; m_term[i] = 0; m_a[i] = 0; m_b[i] = 0; m_value[i] = 0;
    m_valid[i] = 0; m_err[i] = 0; m_perr[i] = 0; m_retry[i] = 0;
    m_pend[i] = 0; m_paddr[i] = 0; m_ack[i] = 0; m_rdata[i] = 0; m_rerr[i] = 0;
  endtask

  task automatic model_serve(input int i, input logic [1:0] a);
    m_ack[i]   = 1'b1;
    m_rerr[i]  = m_err[i];
    m_rdata[i] = m_err[i] ? 8'h00 : m_value[i][int'(a) * 8 +: 8];
  endtask

  task automatic model_step(input int i);
    logic accepted, now, entered;
    entered  = 1'b0;
    accepted = rd_req[i] && !m_pend[i] && !m_ack[i];
    now      = accepted && m_term[i] && !rescan[i];
    if (!m_term[i]) begin
      m_pos[i]++;
      if (m_pos[i] == p_s[i] + 1) m_a[i] = efuse[i];
      else if (m_pos[i] == p_s[i] + 2) m_b[i] = efuse[i];
      else if (m_pos[i] == p_s[i] + 3) begin
        if (m_a[i] != m_b[i]) begin
          if (m_retry[i] < p_mr[i]) begin
            m_retry[i]++;
            m_pos[i] = 0;
          end else begin
            m_err[i] = 1'b1; m_term[i] = 1'b1; entered = 1'b1;
          end
        end else if (p_par[i] != 0 && (^m_a[i])) begin
          m_err[i] = 1'b1; m_perr[i] = 1'b1; m_term[i] = 1'b1; entered = 1'b1;
        end else begin
          m_value[i] = m_a[i]; m_valid[i] = 1'b1; m_term[i] = 1'b1; entered = 1'b1;
        end
      end
    end else if (rescan[i]) begin
      m_term[i] = 1'b0; m_pos[i] = 0; m_valid[i] = 1'b0;
      m_err[i] = 1'b0; m_perr[i] = 1'b0; m_retry[i] = 0;
    end
    m_ack[i] = 1'b0; m_rdata[i] = 8'h00; m_rerr[i] = 1'b0;
    if (accepted && !now) begin
      m_pend[i] = 1'b1; m_paddr[i] = rd_addr[i];
    end
    if (now) model_serve(i, rd_addr[i]);
    else if (m_pend[i] && entered) begin
      model_serve(i, m_paddr[i]);
      m_pend[i] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else model_step(i);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d value", i),      value[i],      m_value[i]);
      chk($sformatf("u%0d valid", i),      32'(valid[i]),      32'(m_valid[i]));
      chk($sformatf("u%0d error", i),      32'(error[i]),      32'(m_err[i]));
      chk($sformatf("u%0d parity_err", i), 32'(parity_err[i]), 32'(m_perr[i]));
      chk($sformatf("u%0d busy", i),       32'(busy[i]),       32'(!m_term[i]));
      chk($sformatf("u%0d retry_cnt", i),  32'(retry_cnt[i]),  32'(m_retry[i]));
      chk($sformatf("u%0d rd_ack", i),     32'(rd_ack[i]),     32'(m_ack[i]));
      chk($sformatf("u%0d rd_data", i),    32'(rd_data[i]),    32'(m_rdata[i]));
      chk($sformatf("u%0d rd_err", i),     32'(rd_err[i]),     32'(m_rerr[i]));
    end
  end

  // ---------------- literal pins (DUT and model) ----------------
  task automatic pin(input int i, input string tag, input logic v, input logic [31:0] val,
                     input logic e, input logic pe, input int rc, input logic b);
    chk($sformatf("%s u%0d valid", tag, i),      32'(valid[i]),      32'(v));
    chk($sformatf("%s u%0d value", tag, i),      value[i],           val);
    chk($sformatf("%s u%0d error", tag, i),      32'(error[i]),      32'(e));
    chk($sformatf("%s u%0d parity_err", tag, i), 32'(parity_err[i]), 32'(pe));
    chk($sformatf("%s u%0d retry_cnt", tag, i),  32'(retry_cnt[i]),  32'(rc));
    chk($sformatf("%s u%0d busy", tag, i),       32'(busy[i]),       32'(b));
    chk($sformatf("%s model u%0d valid", tag, i), 32'(m_valid[i]), 32'(v));
    chk($sformatf("%s model u%0d value", tag, i), m_value[i],      val);
    chk($sformatf("%s model u%0d error", tag, i), 32'(m_err[i]),   32'(e));
    chk($sformatf("%s model u%0d retry", tag, i), 32'(m_retry[i]), 32'(rc));
  endtask

  task automatic pin_rd(input int i, input string tag, input logic a,
                        input logic [7:0] d, input logic e);
    chk($sformatf("%s u%0d rd_ack", tag, i),        32'(rd_ack[i]),  32'(a));
    chk($sformatf("%s u%0d rd_data", tag, i),       32'(rd_data[i]), 32'(d));
    chk($sformatf("%s u%0d rd_err", tag, i),        32'(rd_err[i]),  32'(e));
    chk($sformatf("%s model u%0d rd_ack", tag, i),  32'(m_ack[i]),   32'(a));
    chk($sformatf("%s model u%0d rd_data", tag, i), 32'(m_rdata[i]), 32'(d));
  endtask

  // ---------------- stimulus ----------------
  int   ecount = 0;
  logic tog1   = 1'b1;

  // Advance one clock; afterwards the caller is at the falling edge following
  // edge number ecount and may set inputs for the next edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    ecount++;
    for (int i = 0; i < 2; i++) begin
      rescan[i] = 1'b0;
      rd_req[i] = 1'b0;
    end
    if (tog1) efuse[1] = ~efuse[1];
  endtask

  task automatic run_to(input int e);
    while (ecount < e) step();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rescan[i] = 1'b0; rd_req[i] = 1'b0; rd_addr[i] = 2'd0;
    end
    efuse[0] = 32'hA5C3_0F12;
    efuse[1] = 32'h0F0F_0F0F;
    repeat (3) @(negedge clk);
    pin(0, "reset", 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
    pin_rd(0, "reset", 1'b0, 8'h00, 1'b0);
    pin(1, "reset", 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
    rst_n = 1'b1;
    ecount = 0;

    // u0: read of byte 2 requested mid-scan, second request while pending.
    run_to(1);  rd_req[0] = 1'b1; rd_addr[0] = 2'd2;
    run_to(3);  rd_req[0] = 1'b1; rd_addr[0] = 2'd1;
    run_to(6);  pin(0, "pre-valid", 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
    run_to(7);  pin(0, "first scan", 1'b1, 32'hA5C3_0F12, 1'b0, 1'b0, 0, 1'b0);
                pin_rd(0, "pending read", 1'b1, 8'hC3, 1'b0);
                efuse[0] = 32'hDEAD_BEEF;
    run_to(8);  pin_rd(0, "second req ignored", 1'b0, 8'h00, 1'b0);
                rescan[0] = 1'b1; rd_req[0] = 1'b1; rd_addr[0] = 2'd2;
    run_to(9);  pin(0, "after rescan", 1'b0, 32'hA5C3_0F12, 1'b0, 1'b0, 0, 1'b1);
    run_to(11); rd_req[0] = 1'b1; rd_addr[0] = 2'd0;
    // Word changes between the two samples of the first attempt only.
    run_to(14); efuse[0] = 32'h1122_3344;
    run_to(22); pin(0, "retry pre-valid", 1'b0, 32'hA5C3_0F12, 1'b0, 1'b0, 1, 1'b1);
    run_to(23); pin(0, "retry scan", 1'b1, 32'h1122_3344, 1'b0, 1'b0, 1, 1'b0);
                pin_rd(0, "rescan read", 1'b1, 8'h22, 1'b0);

    // u1: toggling word exhausts the retry budget.
    run_to(24); pin(1, "toggle fail", 1'b0, 32'h0, 1'b1, 1'b0, 2, 1'b0);
                tog1 = 1'b0; efuse[1] = 32'h0000_0001;
                rd_req[1] = 1'b1; rd_addr[1] = 2'd1;
                rd_req[0] = 1'b1; rd_addr[0] = 2'd0;
    run_to(25); pin_rd(1, "read in FAIL", 1'b1, 8'h00, 1'b1);
                pin_rd(0, "b2b first", 1'b1, 8'h44, 1'b0);
                rd_req[0] = 1'b1; rd_addr[0] = 2'd3;
    run_to(26); pin_rd(0, "b2b ack cycle", 1'b0, 8'h00, 1'b0);
                rd_req[0] = 1'b1; rd_addr[0] = 2'd3;
    run_to(27); pin_rd(0, "b2b second", 1'b1, 8'h11, 1'b0);
                rescan[1] = 1'b1;

    // u1: parity failure, no retry; then a good-parity word.
    run_to(35); pin(1, "parity pre-check", 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
    run_to(36); pin(1, "parity fail", 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b0);
                efuse[1] = 32'h8000_0001;
    run_to(37); rescan[1] = 1'b1;
    run_to(45); pin(1, "parity ok pre", 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
    run_to(46); pin(1, "parity ok", 1'b1, 32'h8000_0001, 1'b0, 1'b0, 0, 1'b0);
                rd_req[1] = 1'b1; rd_addr[1] = 2'd3;
    run_to(47); pin_rd(1, "read top byte", 1'b1, 8'h80, 1'b0);
                rescan[0] = 1'b1;

    // u0: pending read, then asynchronous reset mid-scan.
    run_to(49); rd_req[0] = 1'b1; rd_addr[0] = 2'd1;
    run_to(51);
    #2 rst_n = 1'b0;
    #1;
    pin(0, "async reset", 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
    pin_rd(0, "async reset", 1'b0, 8'h00, 1'b0);
    pin(1, "async reset", 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
    repeat (3) @(negedge clk);
    pin_rd(0, "held reset", 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    ecount = 0;
    run_to(7);  pin(0, "post reset scan", 1'b1, 32'h1122_3344, 1'b0, 1'b0, 0, 1'b0);
                pin_rd(0, "dropped read", 1'b0, 8'h00, 1'b0);
    run_to(9);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/efuse_usr_ctrl.md
# efuse_usr_ctrl

Sequencer and read-port controller for the 32-bit user eFuse word.
- After reset it waits a settle interval, then double-samples the eFuse bus and checks that both samples agree; optionally it also checks parity.
- It latches the qualified value and serves byte reads to the register/host side through a req/ack handshake.
- It sits between the eFuse primitive's static output and the configuration registers of the receiver datapath.

## Interface
- SETTLE_CYCLES, 16, settle cycles before each sample pair; legal range 1..65535.
- MAX_RETRY, 3, number of re-scans allowed after a sample mismatch; legal range 0..15.
- PARITY_EN, 0, when 1, bit 31 is even parity over bits [30:0].
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- efuse_usr  in  32  raw eFuse user word
- rescan  in  1  single-cycle pulse that restarts the scan; honoured only in DONE or FAIL
- rd_req  in  1  read request, sampled on each clock edge
- rd_addr  in  2  byte select; 0 selects [7:0], 3 selects [31:24]
- rd_ack  out  1  single-cycle read acknowledge
- rd_data  out  8  selected byte; valid while rd_ack is high
- rd_err  out  1  error flag returned with rd_ack
- value  out  32  qualified eFuse word
- valid  out  1  value is qualified
- error  out  1  scan failed
- parity_err  out  1  the failure was caused by parity
- busy  out  1  a scan is in progress
- retry_cnt  out  4  number of mismatches in the current scan

## Operation
FSM states: SETTLE, CAP_A, CAP_B, CHECK, DONE, FAIL. Reset state is SETTLE with the counter at 0.

Reset values:
- value, valid, error, parity_err, rd_ack, rd_data, rd_err, retry_cnt are all 0.
- busy is 1.

State behaviour:
- **SETTLE:** the counter increments every cycle. When the counter equals SETTLE_CYCLES-1, the FSM goes to CAP_A. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- **CAP_A:** sample_a <= efuse_usr; go to CAP_B.
- **CAP_B:** sample_b <= efuse_usr; go to CHECK.
- **CHECK:** first matching rule wins.
  - sample_a != sample_b and retry_cnt < MAX_RETRY: retry_cnt increments, the counter clears, go to SETTLE.
  - sample_a != sample_b and retry_cnt == MAX_RETRY: error <= 1, go to FAIL.
  - PARITY_EN and ^sample_a == 1: error <= 1, parity_err <= 1, go to FAIL. Parity failure is not retried.
  - Otherwise: value <= sample_a, valid <= 1, go to DONE.
- **DONE / FAIL:** terminal states. A rescan pulse goes to SETTLE. On entering SETTLE from rescan, valid, error, parity_err and retry_cnt clear and the counter clears; value keeps its old contents until the next DONE.

busy = (state is not DONE and not FAIL).

Read port:
- A request is accepted when rd_req is high and no request is pending; rd_addr is captured at acceptance.
- If accepted in DONE or FAIL, and rescan is not high in the same cycle, the request is served on the next cycle.
- Otherwise the request becomes pending and is served in the first cycle after the FSM enters DONE or FAIL.
- Serve: rd_ack=1 for exactly one cycle.
  - rd_data = value byte rd_addr, or 8'h00 when error is set.
  - rd_err = error.
- While a request is pending, or in its ack cycle, rd_req is ignored and not queued.
- If rd_req and rescan are high in the same DONE/FAIL cycle, rescan wins. The request becomes pending and returns post-rescan data.
- Back-to-back reads in DONE: a request is accepted every other cycle at most, with the ack cycle in between.

Widths: the settle counter is 16 bits and retry_cnt is 4 bits; neither can overflow within the legal parameter ranges.

## Timing
- Cycle 1 is the first rising edge with reset_n high.
- With no mismatch, valid rises after edge SETTLE_CYCLES+3. Each mismatch adds SETTLE_CYCLES+3 cycles.
- efuse_usr is sampled at edges SETTLE_CYCLES+1 and SETTLE_CYCLES+2 of each attempt.
- Read latency is 1 cycle in DONE/FAIL. A pending read acks 1 cycle after the state transition, i.e. in the cycle valid or error is first visible high.
- reset_n asserted at any time, including mid-scan or while a read is pending:
  - All outputs return to their reset values immediately (asynchronously).
  - Any pending read is dropped without an ack.
- All outputs are registered.

## Test plan
- SETTLE_CYCLES=4, efuse_usr=32'hA5C3_0F12 held stable. Required: valid=1 after edge 7, value=32'hA5C3_0F12, error=0, retry_cnt=0.
- efuse_usr changes between the CAP_A and CAP_B samples on the first attempt only, MAX_RETRY=3. Required: retry_cnt=1, valid after edge 14 (SETTLE_CYCLES=4), value equal to the stable word.
- efuse_usr toggles on every sample, MAX_RETRY=2. Required: error=1, parity_err=0, retry_cnt=2, FAIL reached. A read then returns rd_data=8'h00 with rd_err=1.
- PARITY_EN=1, efuse_usr=32'h0000_0001. Required: FAIL with parity_err=1 after the first CHECK and no retry. With efuse_usr=32'h8000_0001, DONE is reached.
- rd_req with rd_addr=2 issued in cycle 2 (mid-scan), value 32'h1122_3344. Required: rd_ack in the cycle valid rises, rd_data=8'h22, rd_err=0; a second rd_req issued while the first is pending gets no ack.
- Rescan pulsed in DONE together with rd_req, then reset_n pulsed low mid-scan. Required: valid drops, the read is served after the new scan completes, and after the reset all outputs are at their reset values with no ack.
